// File: rtl/triangle_scanner.sv
// Bounding-box rasteriser front end: latches a fixed-point triangle, clips its
// integer bounding box to the screen and walks it in raster order, one pixel per unstalled cycle.
module triangle_scanner #(
    parameter int SCREEN_W  = 320,
    parameter int SCREEN_H  = 240,
    parameter int FRAC_BITS = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic                i_stall,
    input  logic signed [31:0]  i_v1_x,
    input  logic signed [31:0]  i_v1_y,
    input  logic signed [31:0]  i_v2_x,
    input  logic signed [31:0]  i_v2_y,
    input  logic signed [31:0]  i_v3_x,
    input  logic signed [31:0]  i_v3_y,
    output logic signed [31:0]  o_v1_x,
    output logic signed [31:0]  o_v1_y,
    output logic signed [31:0]  o_v2_x,
    output logic signed [31:0]  o_v2_y,
    output logic signed [31:0]  o_v3_x,
    output logic signed [31:0]  o_v3_y,
    output logic signed [15:0]  o_x_pos,
    output logic signed [15:0]  o_y_pos,
    output logic signed [31:0]  o_vp_x,
    output logic signed [31:0]  o_vp_y,
    output logic                o_write_enable,
    output logic                o_busy,
    output logic                o_done
);

    localparam int unsigned FW = 32;
    localparam int unsigned PW = 16;
    localparam logic signed [FW-1:0] X_LIM = FW'(SCREEN_W - 1);
    localparam logic signed [FW-1:0] Y_LIM = FW'(SCREEN_H - 1);
    localparam logic [FW-1:0]        HALF  = FW'(1) << (FRAC_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_CLIP,
        S_SCAN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic signed [FW-1:0] bx_min, bx_max, by_min, by_max;
    logic signed [PW-1:0] cx_min, cx_max, cy_max;
    logic signed [PW-1:0] x_q, y_q;
    logic signed [FW-1:0] bx_min_c, bx_max_c, by_min_c, by_max_c;
    logic                 off_screen_c, last_px_c;

    function automatic logic signed [FW-1:0] min3(input logic signed [FW-1:0] a,
                                                  input logic signed [FW-1:0] b,
                                                  input logic signed [FW-1:0] c);
        logic signed [FW-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [FW-1:0] max3(input logic signed [FW-1:0] a,
                                                  input logic signed [FW-1:0] b,
                                                  input logic signed [FW-1:0] c);
        logic signed [FW-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic logic signed [PW-1:0] clamp(input logic signed [FW-1:0] v,
                                                   input logic signed [FW-1:0] lim);
        if (v < 0)        return '0;
        else if (v > lim) return PW'(lim);
        else              return PW'(v);
    endfunction

    // Integer (floor) bounding box of the latched vertices.
    always_comb begin
        bx_min_c = min3(o_v1_x, o_v2_x, o_v3_x) >>> FRAC_BITS;
        bx_max_c = max3(o_v1_x, o_v2_x, o_v3_x) >>> FRAC_BITS;
        by_min_c = min3(o_v1_y, o_v2_y, o_v3_y) >>> FRAC_BITS;
        by_max_c = max3(o_v1_y, o_v2_y, o_v3_y) >>> FRAC_BITS;
    end

    assign off_screen_c = (bx_max < 0) || (bx_min > X_LIM) || (by_max < 0) || (by_min > Y_LIM);
    assign last_px_c    = (x_q == cx_max) && (y_q == cy_max);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start) state_d = S_SETUP;
            S_SETUP: state_d = S_CLIP;
            S_CLIP:  state_d = off_screen_c ? S_DONE : S_SCAN;
            S_SCAN:  if (!i_stall && last_px_c) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered outputs; strobes default low every cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_v1_x <= '0; o_v1_y <= '0;
            o_v2_x <= '0; o_v2_y <= '0;
            o_v3_x <= '0; o_v3_y <= '0;
            o_x_pos <= '0; o_y_pos <= '0;
            o_vp_x <= '0; o_vp_y <= '0;
            o_write_enable <= 1'b0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
            bx_min <= '0; bx_max <= '0; by_min <= '0; by_max <= '0;
            cx_min <= '0; cx_max <= '0; cy_max <= '0;
            x_q <= '0; y_q <= '0;
        end else begin
            o_write_enable <= 1'b0;
            o_done         <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        o_v1_x <= i_v1_x; o_v1_y <= i_v1_y;
                        o_v2_x <= i_v2_x; o_v2_y <= i_v2_y;
                        o_v3_x <= i_v3_x; o_v3_y <= i_v3_y;
                        o_busy <= 1'b1;
                    end
                end
                S_SETUP: begin
                    bx_min <= bx_min_c;
                    bx_max <= bx_max_c;
                    by_min <= by_min_c;
                    by_max <= by_max_c;
                end
                S_CLIP: begin
                    cx_min <= clamp(bx_min, X_LIM);
                    cx_max <= clamp(bx_max, X_LIM);
                    cy_max <= clamp(by_max, Y_LIM);
                    x_q    <= clamp(bx_min, X_LIM);
                    y_q    <= clamp(by_min, Y_LIM);
                end
                S_SCAN: begin
                    if (!i_stall) begin
                        o_write_enable <= 1'b1;
                        o_x_pos <= x_q;
                        o_y_pos <= y_q;
                        o_vp_x  <= (FW'(x_q) << FRAC_BITS) | HALF;
                        o_vp_y  <= (FW'(y_q) << FRAC_BITS) | HALF;
                        if (x_q == cx_max) begin
                            x_q <= cx_min;
                            y_q <= y_q + PW'(1);
                        end else begin
                            x_q <= x_q + PW'(1);
                        end
                    end
                end
                S_DONE: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_triangle_scanner.sv
// Bench for triangle_scanner: directed cases plus random triangles scored against
// a floor/clamp bounding-box model of the expected raster order.
module tb_triangle_scanner;

    typedef int tri_t [6];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic stall = 1'b0;
    logic signed [31:0] v1x = 0, v1y = 0, v2x = 0, v2y = 0, v3x = 0, v3y = 0;
    logic signed [31:0] o_v1_x, o_v1_y, o_v2_x, o_v2_y, o_v3_x, o_v3_y;
    logic signed [15:0] o_x_pos, o_y_pos;
    logic signed [31:0] o_vp_x, o_vp_y;
    logic o_write_enable, o_busy, o_done;

    triangle_scanner dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stall(stall),
        .i_v1_x(v1x), .i_v1_y(v1y), .i_v2_x(v2x), .i_v2_y(v2y), .i_v3_x(v3x), .i_v3_y(v3y),
        .o_v1_x(o_v1_x), .o_v1_y(o_v1_y), .o_v2_x(o_v2_x), .o_v2_y(o_v2_y),
        .o_v3_x(o_v3_x), .o_v3_y(o_v3_y),
        .o_x_pos(o_x_pos), .o_y_pos(o_y_pos), .o_vp_x(o_vp_x), .o_vp_y(o_vp_y),
        .o_write_enable(o_write_enable), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int got_x[$], got_y[$], got_vx[$], got_vy[$], got_cyc[$];
    int exp_x[$], exp_y[$];
    int done_cyc;
    bit both_high, vchg, rst_zero, late_activity;

    tri_t tri_a = '{65536, 65536, 229376, 65536, 65536, 144179};
    tri_t tri_off = '{-327680, 65536, -131072, 65536, -196608, 262144};
    tri_t tri_clip = '{-131072, -131072, 98304, -65536, 13107, 124518};

    function automatic int ifloor(input int v);
        return int'($floor(real'(v) / 65536.0));
    endfunction

    // Reference: every integer pixel of the screen-clipped floor bounding box, row-major.
    task automatic build_expected(input tri_t v);
        int xl, xh, yl, yh;
        xl = ifloor(v[0]); xh = xl; yl = ifloor(v[1]); yh = yl;
        for (int i = 1; i < 3; i++) begin
            if (ifloor(v[2*i]) < xl) xl = ifloor(v[2*i]);
            if (ifloor(v[2*i]) > xh) xh = ifloor(v[2*i]);
            if (ifloor(v[2*i+1]) < yl) yl = ifloor(v[2*i+1]);
            if (ifloor(v[2*i+1]) > yh) yh = ifloor(v[2*i+1]);
        end
        exp_x.delete(); exp_y.delete();
        if (xh < 0 || xl > 319 || yh < 0 || yl > 239) return;
        if (xl < 0) xl = 0;
        if (yl < 0) yl = 0;
        if (xh > 319) xh = 319;
        if (yh > 239) yh = 239;
        for (int y = yl; y <= yh; y++)
            for (int x = xl; x <= xh; x++) begin
                exp_x.push_back(x);
                exp_y.push_back(y);
            end
    endtask

    task automatic rand_tri(output tri_t v);
        int cx, cy;
        cx = int'($urandom_range(0, 360)) - 20;
        cy = int'($urandom_range(0, 280)) - 20;
        for (int i = 0; i < 3; i++) begin
            v[2*i]   = (cx + int'($urandom_range(0, 12)) - 6) * 65536 + int'($urandom_range(0, 65535));
            v[2*i+1] = (cy + int'($urandom_range(0, 12)) - 6) * 65536 + int'($urandom_range(0, 65535));
        end
    endtask

    task automatic drive_vertices(input tri_t v);
        v1x = v[0]; v1y = v[1]; v2x = v[2]; v2y = v[3]; v3x = v[4]; v3y = v[5];
    endtask

    // Runs one triangle. mode: 0 plain, 1 random stall, 2 three-cycle stall after
    // pixel 2, 3 re-start with other vertices mid-scan, 4 reset pulse after pixel 4.
    task automatic scan(input tri_t v, input int mode);
        tri_t junk;
        int stall_used;
        got_x.delete(); got_y.delete(); got_vx.delete(); got_vy.delete(); got_cyc.delete();
        done_cyc = -1; both_high = 0; vchg = 0; rst_zero = 1; late_activity = 0;
        stall_used = 0;
        drive_vertices(v);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rand_tri(junk);
        drive_vertices(junk);
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            @(negedge clk);
            if (o_write_enable) begin
                got_x.push_back(int'(o_x_pos)); got_y.push_back(int'(o_y_pos));
                got_vx.push_back(int'(o_vp_x)); got_vy.push_back(int'(o_vp_y));
                got_cyc.push_back(cyc);
            end
            if (o_write_enable && o_done) both_high = 1;
            if (o_busy && (o_v1_x !== v[0] || o_v1_y !== v[1] || o_v2_x !== v[2] ||
                           o_v2_y !== v[3] || o_v3_x !== v[4] || o_v3_y !== v[5])) vchg = 1;
            if (o_done) begin
                done_cyc = cyc;
                break;
            end
            stall = 1'b0;
            start = 1'b0;
            if (mode == 1) stall = ($urandom_range(0, 2) == 0);
            if (mode == 2 && got_x.size() >= 2 && stall_used < 3) begin
                stall = 1'b1;
                stall_used++;
            end
            if (mode == 3 && cyc == 4) begin
                start = 1'b1;
                rand_tri(junk);
                drive_vertices(junk);
            end
            if (mode == 4 && got_x.size() == 4) begin
                rst_n = 1'b0;
                #1;
                rst_zero = !(o_busy || o_done || o_write_enable || (o_x_pos != 0) || (o_y_pos != 0) ||
                             (o_vp_x != 0) || (o_vp_y != 0) || (o_v1_x != 0) || (o_v1_y != 0) ||
                             (o_v2_x != 0) || (o_v2_y != 0) || (o_v3_x != 0) || (o_v3_y != 0));
                @(negedge clk);
                rst_n = 1'b1;
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    if (o_done || o_write_enable || o_busy) late_activity = 1;
                end
                break;
            end
        end
        stall = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        tri_t v;
        rand_tri(v);
        drive_vertices(v);
        start = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", o_busy); end
        n_vec++; if (o_write_enable !== 1'b0) begin n_err++; $display("FAIL reset_we got %b want 0", o_write_enable); end
        n_vec++; if (o_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", o_done); end
        n_vec++; if (o_x_pos !== 16'sd0 || o_y_pos !== 16'sd0) begin n_err++; $display("FAIL reset_pos got %0d,%0d want 0,0", o_x_pos, o_y_pos); end
        n_vec++; if (o_vp_x !== 32'sd0 || o_vp_y !== 32'sd0) begin n_err++; $display("FAIL reset_vp got %h,%h want 0,0", o_vp_x, o_vp_y); end
        n_vec++; if (o_v1_x !== 32'sd0 || o_v3_y !== 32'sd0) begin n_err++; $display("FAIL reset_vtx got %h,%h want 0,0", o_v1_x, o_v3_y); end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        tri_t tbl [3];
        int want_n [3];
        tbl[0] = tri_a; tbl[1] = tri_off; tbl[2] = tri_clip;
        want_n[0] = 6; want_n[1] = 0; want_n[2] = 4;
        for (int t = 0; t < 3; t++) begin
            build_expected(tbl[t]);
            scan(tbl[t], 0);
            n_vec++; if (got_x.size() != want_n[t]) begin n_err++; $display("FAIL dir%0d_count got %0d want %0d", t, got_x.size(), want_n[t]); end
            for (int i = 0; i < got_x.size() && i < exp_x.size(); i++) begin
                n_vec++;
                if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i] || got_vx[i] != exp_x[i]*65536 + 32768 ||
                    got_vy[i] != exp_y[i]*65536 + 32768) begin
                    n_err++;
                    $display("FAIL dir%0d_px%0d got (%0d,%0d) vp %h,%h want (%0d,%0d)", t, i, got_x[i], got_y[i], got_vx[i], got_vy[i], exp_x[i], exp_y[i]);
                end
            end
            n_vec++; if (done_cyc != 3 + want_n[t]) begin n_err++; $display("FAIL dir%0d_done_cycle got %0d want %0d", t, done_cyc, 3 + want_n[t]); end
            n_vec++; if (got_cyc.size() > 0 && got_cyc[0] != 3) begin n_err++; $display("FAIL dir%0d_first_latency got %0d want 3", t, got_cyc[0]); end
            n_vec++; if (both_high || vchg) begin n_err++; $display("FAIL dir%0d_flags got both=%0d vchg=%0d want 0,0", t, both_high, vchg); end
        end
        // Explicit corner values for the clipped case and the first pixel centre.
        n_vec++; if (got_x.size() > 0 && (got_x[0] != 0 || got_y[0] != 0)) begin n_err++; $display("FAIL clip_first got (%0d,%0d) want (0,0)", got_x[0], got_y[0]); end
        scan(tri_a, 0);
        n_vec++; if (got_vx.size() == 0 || got_vx[0] != 32'h00018000) begin n_err++; $display("FAIL first_vp_x got %h want 00018000", got_vx.size() ? got_vx[0] : -1); end
    endtask

    task automatic test_stall();
        build_expected(tri_a);
        scan(tri_a, 2);
        n_vec++; if (got_x.size() != 6) begin n_err++; $display("FAIL stall_count got %0d want 6", got_x.size()); end
        for (int i = 0; i < got_x.size() && i < exp_x.size(); i++) begin
            n_vec++;
            if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) begin
                n_err++; $display("FAIL stall_px%0d got (%0d,%0d) want (%0d,%0d)", i, got_x[i], got_y[i], exp_x[i], exp_y[i]);
            end
        end
        n_vec++; if (done_cyc != 12) begin n_err++; $display("FAIL stall_done_cycle got %0d want 12", done_cyc); end
        n_vec++; if (got_cyc.size() == 6 && got_cyc[2] != 8) begin n_err++; $display("FAIL stall_resume got %0d want 8", got_cyc[2]); end
    endtask

    task automatic test_restart();
        build_expected(tri_a);
        scan(tri_a, 3);
        n_vec++; if (got_x.size() != exp_x.size()) begin n_err++; $display("FAIL restart_count got %0d want %0d", got_x.size(), exp_x.size()); end
        for (int i = 0; i < got_x.size() && i < exp_x.size(); i++) begin
            n_vec++;
            if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) begin
                n_err++; $display("FAIL restart_px%0d got (%0d,%0d) want (%0d,%0d)", i, got_x[i], got_y[i], exp_x[i], exp_y[i]);
            end
        end
        n_vec++; if (vchg) begin n_err++; $display("FAIL restart_vertices got changed want held"); end
        n_vec++; if (done_cyc != 9) begin n_err++; $display("FAIL restart_done_cycle got %0d want 9", done_cyc); end
    endtask

    task automatic test_reset_mid_scan();
        scan(tri_a, 4);
        n_vec++; if (!rst_zero) begin n_err++; $display("FAIL midrst_async got nonzero outputs want all 0"); end
        n_vec++; if (late_activity || done_cyc != -1) begin n_err++; $display("FAIL midrst_quiet got activity=%0d done=%0d want 0,-1", late_activity, done_cyc); end
        build_expected(tri_a);
        scan(tri_a, 0);
        n_vec++; if (got_x.size() != 6) begin n_err++; $display("FAIL midrst_rescan_count got %0d want 6", got_x.size()); end
        for (int i = 0; i < got_x.size() && i < exp_x.size(); i++) begin
            n_vec++;
            if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) begin
                n_err++; $display("FAIL midrst_px%0d got (%0d,%0d) want (%0d,%0d)", i, got_x[i], got_y[i], exp_x[i], exp_y[i]);
            end
        end
        n_vec++; if (done_cyc != 9) begin n_err++; $display("FAIL midrst_done_cycle got %0d want 9", done_cyc); end
    endtask

    task automatic test_random();
        tri_t v;
        int want_done;
        for (int r = 0; r < 30; r++) begin
            rand_tri(v);
            build_expected(v);
            scan(v, r % 2);
            n_vec++; if (got_x.size() != exp_x.size()) begin n_err++; $display("FAIL rnd%0d_count got %0d want %0d", r, got_x.size(), exp_x.size()); end
            for (int i = 0; i < got_x.size() && i < exp_x.size(); i++) begin
                n_vec++;
                if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i] || got_vx[i] != exp_x[i]*65536 + 32768 ||
                    got_vy[i] != exp_y[i]*65536 + 32768) begin
                    n_err++;
                    $display("FAIL rnd%0d_px%0d got (%0d,%0d) want (%0d,%0d)", r, i, got_x[i], got_y[i], exp_x[i], exp_y[i]);
                end
            end
            if (r % 2 == 0) want_done = 3 + exp_x.size();
            else want_done = (got_cyc.size() > 0) ? got_cyc[got_cyc.size()-1] + 1 : 3;
            n_vec++; if (done_cyc != want_done) begin n_err++; $display("FAIL rnd%0d_done_cycle got %0d want %0d", r, done_cyc, want_done); end
            n_vec++; if (both_high || vchg) begin n_err++; $display("FAIL rnd%0d_flags got both=%0d vchg=%0d want 0,0", r, both_high, vchg); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_restart();
        test_reset_mid_scan();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
